// File: rtl/odd_parity_pkg.sv
// Shared types and constants for the odd-parity serial transmitter.
package odd_parity_pkg;

  localparam int unsigned FRAME_BITS = 7;
  localparam int unsigned DATA_BITS  = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

endpackage

// File: rtl/odd_parity_gen.sv
// Combinational odd-parity generator: a+b+c+d+p is always odd.
module odd_parity_gen (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic p
);

  // Invert the even parity so the five-bit total comes out odd
  always_comb begin
    p = ~(a ^ b ^ c ^ d);
  end

endmodule

// File: rtl/odd_parity_serial_tx.sv
// Serial transmitter for one nibble per frame: start, a, b, c, d, odd parity, stop.
// Every bit is held BIT_CYCLES clocks. Optional macro PARITY_ERR_INJECT_EN adds an
// err_inject input that inverts the parity bit of the frame accepted with it.
module odd_parity_serial_tx #(
  parameter int unsigned BIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] din,
  input  logic       din_valid,
`ifdef PARITY_ERR_INJECT_EN
  input  logic       err_inject,
`endif
  output logic       din_ready,
  output logic       tx,
  output logic       p_out,
  output logic       busy,
  output logic       frame_done
);

  import odd_parity_pkg::*;

  localparam logic [7:0] LAST_CNT = 8'(BIT_CYCLES - 1);
  localparam logic [1:0] LAST_IDX = 2'(DATA_BITS - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] data_q, data_d;
  logic       par_q, par_d;
  logic       tx_q, tx_d;
  logic       gen_p;
  logic       inject;
  logic       accept;
  logic       bit_end;

  odd_parity_gen u_gen (
    .a (din[3]),
    .b (din[2]),
    .c (din[1]),
    .d (din[0]),
    .p (gen_p)
  );

`ifdef PARITY_ERR_INJECT_EN
  assign inject = err_inject;
`else
  assign inject = 1'b0;
`endif

  assign accept  = din_valid && (state_q == IDLE);
  assign bit_end = (cnt_q == LAST_CNT);

  // Next-state, counters, latched frame and the tx value for the next cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    par_d   = par_q;
    tx_d    = 1'b1;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          data_d  = din;
          par_d   = gen_p ^ inject;
          cnt_d   = 8'd0;
          idx_d   = 2'd0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = 8'd0;
          if (idx_q == LAST_IDX) begin
            state_d = PARITY;
            idx_d   = 2'd0;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
        idx_d   = 2'd0;
      end
    endcase

    // tx is registered, so derive it from where the FSM will be next cycle
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_d[2'd3 - idx_d];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  // State registers with synchronous reset taking priority over accept
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= 2'd0;
      data_q  <= 4'd0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  // Status outputs decoded from the registered state
  always_comb begin
    din_ready  = (state_q == IDLE);
    busy       = (state_q != IDLE);
    frame_done = (state_q == STOP) && bit_end;
    tx         = tx_q;
    p_out      = par_q;
  end

endmodule
